// File: rtl/regdisp_root_arb_if.sv
// Master-side request/completion bus and downstream reg_native bus of regdisp_root_arb.
// The slave modport is the arbiter's view; master is the environment's view.
interface regdisp_root_arb_if #(
  parameter int unsigned MST_NUM    = 2,
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [MST_NUM-1:0]            mst_req_vld;
  logic [MST_NUM*ADDR_WIDTH-1:0] mst_addr;
  logic [MST_NUM-1:0]            mst_wr_en;
  logic [MST_NUM-1:0]            mst_rd_en;
  logic [MST_NUM*DATA_WIDTH-1:0] mst_wr_data;
  logic [MST_NUM-1:0]            mst_soft_rst;
  logic [MST_NUM-1:0]            mst_ack_vld;
  logic                          mst_err;
  logic [DATA_WIDTH-1:0]         mst_rd_data;

  logic                          upstream__regdisp_root_map__req_vld;
  logic                          upstream__regdisp_root_map__wr_en;
  logic                          upstream__regdisp_root_map__rd_en;
  logic [ADDR_WIDTH-1:0]         upstream__regdisp_root_map__addr;
  logic [DATA_WIDTH-1:0]         upstream__regdisp_root_map__wr_data;
  logic                          upstream__regdisp_root_map__soft_rst;
  logic                          regdisp_root_map__upstream__ack_vld;
  logic                          regdisp_root_map__upstream__err;
  logic [DATA_WIDTH-1:0]         regdisp_root_map__upstream__rd_data;

  modport slave (
    input  mst_req_vld, mst_addr, mst_wr_en, mst_rd_en, mst_wr_data, mst_soft_rst,
    output mst_ack_vld, mst_err, mst_rd_data,
    output upstream__regdisp_root_map__req_vld, upstream__regdisp_root_map__wr_en,
    output upstream__regdisp_root_map__rd_en, upstream__regdisp_root_map__addr,
    output upstream__regdisp_root_map__wr_data, upstream__regdisp_root_map__soft_rst,
    input  regdisp_root_map__upstream__ack_vld, regdisp_root_map__upstream__err,
    input  regdisp_root_map__upstream__rd_data
  );

  modport master (
    output mst_req_vld, mst_addr, mst_wr_en, mst_rd_en, mst_wr_data, mst_soft_rst,
    input  mst_ack_vld, mst_err, mst_rd_data,
    input  upstream__regdisp_root_map__req_vld, upstream__regdisp_root_map__wr_en,
    input  upstream__regdisp_root_map__rd_en, upstream__regdisp_root_map__addr,
    input  upstream__regdisp_root_map__wr_data, upstream__regdisp_root_map__soft_rst,
    output regdisp_root_map__upstream__ack_vld, regdisp_root_map__upstream__err,
    output regdisp_root_map__upstream__rd_data
  );
endinterface

// File: rtl/regdisp_root_arb.sv
// Round-robin arbiter serializing MST_NUM register masters onto the single
// upstream port of regdisp_root_map, one outstanding access at a time, with timeout.
module regdisp_root_arb #(
  parameter int unsigned MST_NUM        = 2,
  parameter int unsigned ADDR_WIDTH     = 48,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_CNT_WIDTH   = 8
) (
  input  logic               regdisp_root_map_clk,
  input  logic               regdisp_root_map_rst_n,
  regdisp_root_arb_if.slave  bus
);

  localparam int unsigned IDX_W = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                  state_q,   state_d;
  logic [IDX_W-1:0]        ptr_q,     ptr_d;
  logic [IDX_W-1:0]        gnt_q,     gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic                    wr_en_q,   wr_en_d;
  logic                    rd_en_q,   rd_en_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    err_q,     err_d;
  logic [DATA_WIDTH-1:0]   rd_q,      rd_d;
  logic [TO_CNT_WIDTH-1:0] to_cnt_q,  to_cnt_d;

  logic                    win_vld_c;
  logic [IDX_W-1:0]        win_idx_c;
  logic [IDX_W-1:0]        cand_c;
  logic [ADDR_WIDTH-1:0]   win_addr_c;
  logic [DATA_WIDTH-1:0]   win_wr_data_c;
  logic                    win_wr_en_c;
  logic                    win_rd_en_c;
  logic                    dn_ack_c;
  logic [MST_NUM-1:0]      ack_vec_c;
  logic                    dn_act_c;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned sum;
    sum = 32'(base) + off;
    return IDX_W'(sum % MST_NUM);
  endfunction

  // First requester at or above ptr, wrapping modulo MST_NUM
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = '0;
    cand_c    = '0;
    for (int unsigned i = 0; i < MST_NUM; i++) begin
      cand_c = wrap_idx(ptr_q, i);
      if (!win_vld_c && bus.mst_req_vld[cand_c]) begin
        win_vld_c = 1'b1;
        win_idx_c = cand_c;
      end
    end
  end

  assign win_addr_c    = bus.mst_addr[32'(win_idx_c) * ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wr_data_c = bus.mst_wr_data[32'(win_idx_c) * DATA_WIDTH +: DATA_WIDTH];
  assign win_wr_en_c   = bus.mst_wr_en[win_idx_c];
  assign win_rd_en_c   = bus.mst_rd_en[win_idx_c];
  assign dn_ack_c      = bus.regdisp_root_map__upstream__ack_vld;

  always_ff @(posedge regdisp_root_map_clk or negedge regdisp_root_map_rst_n) begin
    if (!regdisp_root_map_rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      rd_q      <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    rd_d      = rd_q;
    to_cnt_d  = to_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_vld_c) begin
          gnt_d     = win_idx_c;
          addr_d    = win_addr_c;
          wr_en_d   = win_wr_en_c;
          rd_en_d   = win_rd_en_c;
          wr_data_d = win_wr_data_c;
          rd_d      = '0;
          // Neither or both of wr/rd: complete with error, never issued downstream
          if (win_wr_en_c == win_rd_en_c) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        to_cnt_d = '0;
        if (dn_ack_c) begin
          err_d   = bus.regdisp_root_map__upstream__err;
          rd_d    = bus.regdisp_root_map__upstream__rd_data;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        to_cnt_d = to_cnt_q + TO_CNT_WIDTH'(1);
        // A real ack outranks a timeout landing in the same cycle
        if (dn_ack_c) begin
          err_d   = bus.regdisp_root_map__upstream__err;
          rd_d    = bus.regdisp_root_map__upstream__rd_data;
          state_d = ST_RESP;
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          err_d   = 1'b1;
          rd_d    = '0;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        ptr_d   = wrap_idx(gnt_q, 1);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Completion to the granted master, decoded from registered state only
  always_comb begin
    ack_vec_c = '0;
    if (state_q == ST_RESP) begin
      ack_vec_c[gnt_q] = 1'b1;
    end
  end

  assign dn_act_c = (state_q != ST_IDLE);

  assign bus.mst_ack_vld = ack_vec_c;
  assign bus.mst_err     = (state_q == ST_RESP) ? err_q : 1'b0;
  assign bus.mst_rd_data = (state_q == ST_RESP) ? rd_q : '0;

  assign bus.upstream__regdisp_root_map__req_vld  = (state_q == ST_ISSUE);
  assign bus.upstream__regdisp_root_map__wr_en    = dn_act_c ? wr_en_q : 1'b0;
  assign bus.upstream__regdisp_root_map__rd_en    = dn_act_c ? rd_en_q : 1'b0;
  assign bus.upstream__regdisp_root_map__addr     = dn_act_c ? addr_q : '0;
  assign bus.upstream__regdisp_root_map__wr_data  = dn_act_c ? wr_data_q : '0;

  // Soft reset passes straight through regardless of arbitration state
  assign bus.upstream__regdisp_root_map__soft_rst = |bus.mst_soft_rst;

endmodule
